// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_arb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FORCE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of pipeline writeback, MDU handshake, register-file and hazard signals.
interface wb_arbiter_if;
   import wb_arb_pkg::*;

   logic                  wb_we_i;
   logic [REG_ADDR_W-1:0] wb_rd_i;
   logic [DATA_W-1:0]     wb_data_i;
   logic                  mdu_valid_i;
   logic [REG_ADDR_W-1:0] mdu_rd_i;
   logic [DATA_W-1:0]     mdu_data_i;
   logic                  mdu_ready_o;
   logic                  rf_we_o;
   logic [REG_ADDR_W-1:0] rf_rd_o;
   logic [DATA_W-1:0]     rf_data_o;
   logic                  stall_o;
   logic                  pending_o;
   logic [REG_ADDR_W-1:0] pending_rd_o;
   logic                  drop_o;

   // The arbiter itself; drives the register file and hazard outputs.
   modport slave (
      input  wb_we_i, wb_rd_i, wb_data_i, mdu_valid_i, mdu_rd_i, mdu_data_i,
      output mdu_ready_o, rf_we_o, rf_rd_o, rf_data_o,
      output stall_o, pending_o, pending_rd_o, drop_o
   );

   // The surrounding pipeline/MDU side.
   modport master (
      output wb_we_i, wb_rd_i, wb_data_i, mdu_valid_i, mdu_rd_i, mdu_data_i,
      input  mdu_ready_o, rf_we_o, rf_rd_o, rf_data_o,
      input  stall_o, pending_o, pending_rd_o, drop_o
   );

endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// wait in a one-entry buffer and force a one-cycle stall after MAX_WAIT blocked cycles.
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input logic         clk_i,
   input logic         rst_n_i,
   wb_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   arb_state_e            state_q;
   logic [REG_ADDR_W-1:0] buf_rd_q;
   logic [DATA_W-1:0]     buf_data_q;
   logic [CNT_W-1:0]      wait_cnt_q;
   logic                  drop_q;

   logic wb_active;
   logic use_buf;

   assign wb_active = bus.wb_we_i && (bus.wb_rd_i != '0);
   assign use_buf   = (state_q == FORCE) || ((state_q == HOLD) && !wb_active);

   // In HOLD and FORCE someone always writes: either the buffer or the pipeline.
   assign bus.rf_we_o      = rst_n_i && ((state_q != IDLE) || wb_active);
   assign bus.rf_rd_o      = use_buf ? buf_rd_q   : bus.wb_rd_i;
   assign bus.rf_data_o    = use_buf ? buf_data_q : bus.wb_data_i;
   assign bus.mdu_ready_o  = rst_n_i && (state_q == IDLE);
   assign bus.stall_o      = (state_q == FORCE);
   assign bus.pending_o    = (state_q != IDLE);
   assign bus.pending_rd_o = (state_q != IDLE) ? buf_rd_q : '0;
   assign bus.drop_o       = drop_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         buf_rd_q   <= '0;
         buf_data_q <= '0;
         wait_cnt_q <= '0;
         drop_q     <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // Results aimed at r0 complete the handshake but are never buffered.
               if (bus.mdu_valid_i && (bus.mdu_rd_i != '0)) begin
                  buf_rd_q   <= bus.mdu_rd_i;
                  buf_data_q <= bus.mdu_data_i;
                  wait_cnt_q <= '0;
                  state_q    <= HOLD;
               end
            end
            HOLD: begin
               if (!wb_active) begin
                  state_q <= IDLE;
               end else if (bus.wb_rd_i == buf_rd_q) begin
                  // The younger pipeline write to the same rd makes the buffer stale.
                  drop_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_q <= FORCE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            FORCE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized self-checking bench for wb_arbiter against a transaction-level model.
module tb_wb_arbiter;
   import wb_arb_pkg::*;

   localparam int MAX_WAIT = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   wb_arbiter_if bus ();

   wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: a parked result, how many cycles it has been blocked, and whether
   // this cycle is the forced drain.
   bit          m_pend;
   bit          m_force;
   bit          m_drop;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   int          m_blocked;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_pend    = 1'b0;
      m_force   = 1'b0;
      m_drop    = 1'b0;
      m_rd      = '0;
      m_data    = '0;
      m_blocked = 0;
   endtask

   // Expected outputs for the current inputs and model contents.
   task automatic checkAll();
      bit          active;
      bit          e_we;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      active = bus.wb_we_i && (bus.wb_rd_i != 0);
      if (m_force || (m_pend && !active)) begin
         e_we = 1'b1; e_rd = m_rd; e_data = m_data;
      end else begin
         e_we = active || m_pend; e_rd = bus.wb_rd_i; e_data = bus.wb_data_i;
      end
      checkOutput("ready",      32'(bus.mdu_ready_o),  32'(!m_pend));
      checkOutput("rf_we",      32'(bus.rf_we_o),      32'(e_we));
      checkOutput("rf_rd",      32'(bus.rf_rd_o),      32'(e_rd));
      checkOutput("rf_data",    bus.rf_data_o,         e_data);
      checkOutput("stall",      32'(bus.stall_o),      32'(m_force));
      checkOutput("pending",    32'(bus.pending_o),    32'(m_pend));
      checkOutput("pending_rd", 32'(bus.pending_rd_o), m_pend ? 32'(m_rd) : 32'd0);
      checkOutput("drop",       32'(bus.drop_o),       32'(m_drop));
   endtask

   task automatic modelStep(output bit xfer);
      bit active;
      active = bus.wb_we_i && (bus.wb_rd_i != 0);
      xfer   = bus.mdu_valid_i && !m_pend;
      m_drop = m_pend && !m_force && active && (bus.wb_rd_i == m_rd);
      if (m_force) begin
         m_pend  = 1'b0;
         m_force = 1'b0;
      end else if (m_pend) begin
         if (!active || bus.wb_rd_i == m_rd) begin
            m_pend = 1'b0;
         end else begin
            m_blocked++;
            if (m_blocked == MAX_WAIT) m_force = 1'b1;
         end
      end else if (bus.mdu_valid_i && bus.mdu_rd_i != 0) begin
         m_pend    = 1'b1;
         m_rd      = bus.mdu_rd_i;
         m_data    = bus.mdu_data_i;
         m_blocked = 0;
      end
   endtask

   task automatic applyStimulus(input bit we, input logic [4:0] rd, input logic [31:0] data,
                                input bit mv, input logic [4:0] mrd, input logic [31:0] mdata,
                                output bit xfer);
      @(negedge clk);
      bus.wb_we_i     = we;
      bus.wb_rd_i     = rd;
      bus.wb_data_i   = data;
      bus.mdu_valid_i = mv;
      bus.mdu_rd_i    = mrd;
      bus.mdu_data_i  = mdata;
      #1;
      checkAll();
      @(posedge clk);
      modelStep(xfer);
   endtask

   initial begin
      bit          xfer;
      bit          mv;
      bit          mv_hold;
      logic [4:0]  mrd;
      logic [31:0] mdata;

      rst_n           = 1'b0;
      bus.wb_we_i     = 1'b1;
      bus.wb_rd_i     = 5'd3;
      bus.wb_data_i   = 32'h1234;
      bus.mdu_valid_i = 1'b0;
      bus.mdu_rd_i    = '0;
      bus.mdu_data_i  = '0;
      modelReset();

      // Outputs held quiet while reset is asserted, even with an active pipeline write.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready",   32'(bus.mdu_ready_o), 32'd0);
      checkOutput("rst_rf_we",   32'(bus.rf_we_o),     32'd0);
      checkOutput("rst_stall",   32'(bus.stall_o),     32'd0);
      checkOutput("rst_pending", 32'(bus.pending_o),   32'd0);
      checkOutput("rst_drop",    32'(bus.drop_o),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle pipeline: one-cycle MDU latency.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, xfer);
      checkOutput("t1_xfer", 32'(xfer), 32'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, xfer);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, xfer);

      // Starvation: four blocked cycles, then a forced drain.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, xfer);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, xfer);

      // Younger pipeline write to the buffered rd discards the buffer.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, xfer);
      applyStimulus(1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'h0, xfer);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, xfer);

      // rd=0 on both sides: MDU result discarded, pipeline write not active.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, xfer);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0, xfer);
      applyStimulus(1'b1, 5'd0, 32'hAB, 1'b0, 5'd0, 32'h0, xfer);

      // Reset asserted in the middle of a FORCE cycle.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, xfer);
      for (int i = 0; i < MAX_WAIT; i++)
         applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, xfer);
      checkOutput("pre_force", 32'(m_force), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("force_stall", 32'(bus.stall_o), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rf_stall",   32'(bus.stall_o),     32'd0);
      checkOutput("rf_pending", 32'(bus.pending_o),   32'd0);
      checkOutput("rf_we",      32'(bus.rf_we_o),     32'd0);
      checkOutput("rf_ready",   32'(bus.mdu_ready_o), 32'd0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, xfer);

      // Random traffic; the MDU keeps its request stable until it transfers.
      mv_hold = 1'b0;
      mv = 1'b0; mrd = '0; mdata = '0;
      for (int c = 0; c < 600; c++) begin
         if (!mv_hold) begin
            mv    = ($urandom_range(0, 2) == 0);
            mrd   = 5'($urandom_range(0, 7));
            mdata = $urandom;
         end
         applyStimulus(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                       mv, mrd, mdata, xfer);
         mv_hold = mv && !xfer;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
